// File: rtl/move_collector_if.sv
// Square-side drain, move-list read port and status signals of move_collector.
interface move_collector_if #(
   parameter int NSQ = 64,
   parameter int AW  = 8
);
   logic              start;
   logic [NSQ-1:0]    sq_done;
   logic [NSQ-1:0]    sq_valid;
   logic [NSQ*48-1:0] sq_data;
   logic [NSQ-1:0]    sq_rd;
   logic [AW-1:0]     rd_addr;
   logic [11:0]       rd_data;
   logic [AW:0]       move_count;
   logic              list_done;
   logic              overflow;
   logic [15:0]       cycle_count;

   modport master (
      output start, sq_done, sq_valid, sq_data, rd_addr,
      input  sq_rd, rd_data, move_count, list_done, overflow, cycle_count
   );

   modport slave (
      input  start, sq_done, sq_valid, sq_data, rd_addr,
      output sq_rd, rd_data, move_count, list_done, overflow, cycle_count
   );
endinterface

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs round-robin into a move-list RAM.
// MOVE_COLLECTOR_PERF_EN builds the active-cycle counter behind cycle_count.
//
// state  | meaning
// IDLE   | after reset, waiting for the first start
// SCAN   | visiting one square per cycle, popping the first non-empty FIFO
// UNPACK | writing the latched word's valid slots, one per cycle
// FINISH | list complete, outputs held until the next start
module move_collector #(
   parameter int NSQ   = 64,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic            clk,
   input  logic            reset,
   move_collector_if.slave bus
);
   localparam int IW = $clog2(NSQ);

   typedef enum logic [1:0] {IDLE, SCAN, UNPACK, FINISH} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            settle_q, settle_d;
   logic [47:0]     lat_word_q;
   logic [IW-1:0]   lat_idx_q;
   logic [7:0]      slot_vld_q;
   logic [AW:0]     move_count_q;
   logic            list_done_q;
   logic            overflow_q;
   logic [11:0]     rd_data_q;
   logic [11:0]     mem [DEPTH];

   logic [NSQ-1:0]  sq_rd;
   logic            load;
   logic            wr_req;
   logic            wr_en;
   logic            fin;
   logic            full;
   logic            all_idle;
   logic [47:0]     head_word;
   logic [7:0]      head_vld;
   logic [2:0]      sel_k;
   logic [5:0]      slot_val;
   logic [11:0]     wr_move;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
      return (p == IW'(NSQ - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_word = bus.sq_data[int'(ptr_q)*48 +: 48];
   assign all_idle  = (&bus.sq_done) && !(|bus.sq_valid);
   assign full      = (move_count_q == (AW+1)'(DEPTH));
   assign wr_en     = wr_req && !full;
   assign slot_val  = lat_word_q[int'(sel_k)*6 +: 6];
   assign wr_move   = {slot_val, lat_idx_q};

   // A slot holding the owning square's own index is an empty slot.
   always_comb begin
      head_vld = '0;
      for (int k = 0; k < 8; k++)
         head_vld[k] = (head_word[k*6 +: 6] != ptr_q);
   end

   always_comb begin
      sel_k = '0;
      for (int k = 7; k >= 0; k--)
         if (slot_vld_q[k]) sel_k = 3'(k);
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      settle_d = settle_q;
      sq_rd    = '0;
      load     = 1'b0;
      wr_req   = 1'b0;
      fin      = 1'b0;
      if (bus.start) begin
         state_d  = SCAN;
         ptr_d    = '0;
         settle_d = 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (bus.sq_valid[ptr_q]) begin
                  sq_rd[ptr_q] = 1'b1;
                  load         = 1'b1;
                  settle_d     = 1'b0;
                  state_d      = UNPACK;
               end else begin
                  ptr_d = nxt(ptr_q);
                  if (all_idle) begin
                     // Second consecutive idle cycle closes the list.
                     if (settle_q) begin
                        fin      = 1'b1;
                        settle_d = 1'b0;
                        state_d  = FINISH;
                     end else begin
                        settle_d = 1'b1;
                     end
                  end else begin
                     settle_d = 1'b0;
                  end
               end
            end
            UNPACK: begin
               settle_d = 1'b0;
               if (|slot_vld_q) begin
                  wr_req = 1'b1;
               end else begin
                  ptr_d   = nxt(lat_idx_q);
                  state_d = SCAN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         settle_q     <= 1'b0;
         lat_word_q   <= '0;
         lat_idx_q    <= '0;
         slot_vld_q   <= '0;
         move_count_q <= '0;
         list_done_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         settle_q <= settle_d;
         if (bus.start) begin
            slot_vld_q   <= '0;
            move_count_q <= '0;
            list_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
         end else begin
            if (load) begin
               lat_word_q <= head_word;
               lat_idx_q  <= ptr_q;
               slot_vld_q <= head_vld;
            end else if (wr_req) begin
               slot_vld_q[sel_k] <= 1'b0;
            end
            // A full list drops the move but keeps draining the FIFOs.
            if (wr_req) begin
               if (full) overflow_q   <= 1'b1;
               else      move_count_q <= move_count_q + 1'b1;
            end
            if (fin) list_done_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[move_count_q[AW-1:0]] <= wr_move;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= mem[bus.rd_addr];
   end

`ifdef MOVE_COLLECTOR_PERF_EN
   logic [15:0] cyc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
      end else if (bus.start) begin
         cyc_q <= '0;
      end else if ((state_q == SCAN || state_q == UNPACK) && !list_done_q
                   && cyc_q != 16'hFFFF) begin
         cyc_q <= cyc_q + 1'b1;
      end
   end

   assign bus.cycle_count = cyc_q;
`else
   assign bus.cycle_count = '0;
`endif

   assign bus.sq_rd      = sq_rd;
   assign bus.rd_data    = rd_data_q;
   assign bus.move_count = move_count_q;
   assign bus.list_done  = list_done_q;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_move_collector.sv
// Scoreboard bench for move_collector: one-word FIFO model per square, queued
// expectations (pops and status/read values) checked by a single monitor.
module tb_move_collector;
   localparam int NSQ   = 64;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   move_collector_if #(.NSQ(NSQ), .AW(AW)) bus();

   move_collector #(.NSQ(NSQ), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Square FIFO model: at most one word per square.
   logic [NSQ-1:0] fvld;
   logic [47:0]    fword [NSQ];
   logic           push_req  = 1'b0;
   int             push_sq   = 0;
   logic [47:0]    push_word = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fvld <= '0;
      end else begin
         fvld <= (fvld & ~bus.sq_rd) | (push_req ? (NSQ'(1) << push_sq) : '0);
         if (push_req) fword[push_sq] <= push_word;
      end
   end

   assign bus.sq_valid = fvld;

   always_comb begin
      bus.sq_data = '0;
      for (int i = 0; i < NSQ; i++) bus.sq_data[48*i +: 48] = fword[i];
   end

   // Scoreboard
   typedef struct { int sel; int exp; int tag; } exp_t;
   exp_t stat_q[$];
   int   pop_q[$];
   int   nchk = 0;
   int   nerr = 0;

   function automatic string sel_name(input int sel);
      case (sel)
         0: return "move_count";
         1: return "list_done";
         2: return "overflow";
         3: return "cycle_count";
         4: return "rd_data";
         default: return "pending_pops";
      endcase
   endfunction

   function automatic int actual(input int sel);
      case (sel)
         0: return int'(bus.move_count);
         1: return int'(bus.list_done);
         2: return int'(bus.overflow);
         3: return int'(bus.cycle_count);
         4: return int'(bus.rd_data);
         default: return pop_q.size();
      endcase
   endfunction

   function automatic int onehot_idx(input logic [NSQ-1:0] v);
      for (int i = 0; i < NSQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin : monitor
      int   e;
      int   idx;
      int   act;
      exp_t x;
      if (!reset && bus.sq_rd != '0) begin
         nchk++;
         idx = onehot_idx(bus.sq_rd);
         if (!$onehot(bus.sq_rd)) begin
            nerr++;
            $display("FAIL pop_onehot: sq_rd=%h, required a single bit", bus.sq_rd);
         end else if (pop_q.size() == 0) begin
            nerr++;
            $display("FAIL pop_unexpected: square %0d popped, required no pop", idx);
         end else begin
            e = pop_q.pop_front();
            if (idx != e) begin
               nerr++;
               $display("FAIL pop_order: square %0d popped, required %0d", idx, e);
            end
         end
      end
      while (stat_q.size() > 0) begin
         x   = stat_q.pop_front();
         act = actual(x.sel);
         nchk++;
         if (act != x.exp) begin
            nerr++;
            $display("FAIL %s tag%0d: got %0d, required %0d", sel_name(x.sel), x.tag, act, x.exp);
         end
      end
   end

   // Stimulus helpers: everything is driven 2 time units after a rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_v(input int sel, input int exp, input int tag);
      exp_t x;
      x.sel = sel; x.exp = exp; x.tag = tag;
      stat_q.push_back(x);
   endtask

   task automatic push(input int sq, input logic [47:0] w);
      push_req  = 1'b1;
      push_sq   = sq;
      push_word = w;
      tick();
      push_req  = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int max, input int tag);
      int n = 0;
      while (!bus.list_done && n < max) begin
         tick();
         n++;
      end
      expect_v(1, 1, tag);
   endtask

   task automatic rd_chk(input int addr, input int exp, input int tag);
      bus.rd_addr = AW'(addr);
      tick();
      expect_v(4, exp, tag);
   endtask

   function automatic logic [47:0] mk(input logic [5:0] s0, s1, s2, s3, s4, s5, s6, s7);
      return {s7, s6, s5, s4, s3, s2, s1, s0};
   endfunction

   function automatic logic [47:0] seqw(input int self, input int n, input int base);
      logic [47:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) w[6*k +: 6] = (k < n) ? 6'(base + k) : 6'(self);
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   initial begin
      int n;
      int exp_cyc;
`ifdef MOVE_COLLECTOR_PERF_EN
      exp_cyc = 2;
`else
      exp_cyc = 0;
`endif
      bus.start   = 1'b0;
      bus.sq_done = '0;
      bus.rd_addr = '0;

      // Reset state
      repeat (2) tick();
      expect_v(0, 0, 1);
      expect_v(1, 0, 2);
      expect_v(2, 0, 3);
      expect_v(4, 0, 4);
      expect_v(3, 0, 5);
      tick();
      reset = 1'b0;
      tick();
      bus.sq_done = '1;

      // Square 9: slot0=0, slot1=o22, rest empty
      push(9, mk(6'o00, 6'o22, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9));
      pop_q.push_back(9);
      pulse_start();
      wait_done(200, 10);
      expect_v(0, 2, 11);
      expect_v(2, 0, 12);
      rd_chk(0, 12'o0011, 13);
      rd_chk(1, 12'o2211, 14);
      repeat (3) tick();
      expect_v(1, 1, 15);

      // Squares 63 and 0 each hold one single-move word
      push(63, mk(6'd7, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63));
      push(0, mk(6'd5, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
      pop_q.push_back(0);
      pop_q.push_back(63);
      pulse_start();
      wait_done(400, 20);
      expect_v(0, 2, 21);
      rd_chk(0, {6'd5, 6'd0}, 22);
      rd_chk(1, {6'd7, 6'd63}, 23);

      // 260 moves over 33 words: list saturates at DEPTH
      for (int s = 0; s < 32; s++) push(s, seqw(s, 8, s + 1));
      push(32, seqw(32, 4, 33));
      for (int s = 0; s <= 32; s++) pop_q.push_back(s);
      pulse_start();
      wait_done(2000, 30);
      expect_v(0, 256, 31);
      expect_v(2, 1, 32);
      expect_v(5, 0, 33);
      rd_chk(0, {6'd1, 6'd0}, 34);
      rd_chk(2, {6'd3, 6'd0}, 35);
      rd_chk(128, {6'd17, 6'd16}, 36);
      rd_chk(255, {6'd39, 6'd31}, 37);

      // Start in the 3rd UNPACK cycle of an 8-slot word on square 4
      push(4, seqw(4, 8, 8));
      pop_q.push_back(4);
      pop_q.push_back(1);
      pop_q.push_back(6);
      pulse_start();
      n = 0;
      while (bus.move_count != 1 && n < 100) begin
         tick();
         n++;
      end
      push(1, mk(6'd20, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1));
      expect_v(0, 2, 40);
      push_req  = 1'b1;
      push_sq   = 6;
      push_word = mk(6'd21, 6'd6, 6'd6, 6'd6, 6'd6, 6'd6, 6'd6, 6'd6);
      bus.start = 1'b1;
      tick();
      push_req  = 1'b0;
      bus.start = 1'b0;
      expect_v(0, 0, 41);
      expect_v(2, 0, 42);
      expect_v(1, 0, 43);
      wait_done(400, 44);
      expect_v(0, 2, 45);
      rd_chk(0, {6'd20, 6'd1}, 46);
      rd_chk(1, {6'd21, 6'd6}, 47);
      rd_chk(2, {6'd3, 6'd0}, 48);

      // sq_valid[40] rises one cycle after start with everything done
      pop_q.push_back(40);
      pulse_start();
      push(40, mk(6'd1, 6'd40, 6'd40, 6'd40, 6'd40, 6'd40, 6'd40, 6'd40));
      expect_v(1, 0, 50);
      wait_done(400, 51);
      expect_v(0, 1, 52);
      expect_v(5, 0, 53);
      rd_chk(0, {6'd1, 6'd40}, 54);

      // Empty board: list_done after two SCAN cycles
      pulse_start();
      expect_v(1, 0, 60);
      tick();
      expect_v(1, 0, 61);
      tick();
      expect_v(1, 1, 62);
      expect_v(0, 0, 63);
      expect_v(2, 0, 64);
      expect_v(3, exp_cyc, 65);
      repeat (4) tick();
      expect_v(3, exp_cyc, 66);
      expect_v(1, 1, 67);

      expect_v(5, 0, 99);
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
